// File: rtl/ether_cmd_rx.sv
// Serial PHY-enable command frame receiver (58-bit frames, MSB-first).
// Optional frame timeout enabled by defining ETHER_CMD_RX_TIMEOUT_EN.
module ether_cmd_rx #(
`ifdef ETHER_CMD_RX_TIMEOUT_EN
    parameter int          TIMEOUT_CYC = 2048,
`endif
    parameter logic [16:0] HDR_PATTERN = 17'b00011000000000000,
    parameter logic [4:0]  TRL_PATTERN = 5'b11000
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        ser_clk_in,
    input  logic        ser_data_in,
    output logic [15:0] word_a_out,
    output logic [15:0] word_b_out,
    output logic        frame_valid_out,
    output logic        frame_err_out,
    output logic        busy_out,
    output logic [7:0]  frame_count_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_CHECK
    } state_t;

    state_t      r_state;
    logic        r_clk_s1, r_clk_s2, r_clk_s3;
    logic        r_dat_s1, r_dat_s2;
    logic [57:0] r_sr;
    logic [5:0]  r_bits;
    logic [15:0] r_word_a, r_word_b;
    logic        r_valid, r_err, r_busy;
    logic [7:0]  r_count;

    logic w_sample;
    logic w_bit;
    logic w_good;

`ifdef ETHER_CMD_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC);
    logic [TO_W-1:0] r_to_cnt;
    logic [TO_W-1:0] w_to_next;
    logic            w_to_hit;

    assign w_to_next = r_to_cnt + 1'b1;
    assign w_to_hit  = (w_to_next == TO_W'(TIMEOUT_CYC - 1));
`endif

    // Line idles high, so synchronizers come out of reset at 1.
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_clk_s3 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ser_clk_in;
            r_clk_s2 <= r_clk_s1;
            r_clk_s3 <= r_clk_s2;
            r_dat_s1 <= ser_data_in;
            r_dat_s2 <= r_dat_s1;
        end
    end

    assign w_sample = r_clk_s2 & ~r_clk_s3;
    assign w_bit    = r_dat_s2;

    assign w_good = (r_sr[57:41] == HDR_PATTERN) &&
                    (r_sr[40:39] == 2'b11) &&
                    (r_sr[22:21] == 2'b11) &&
                    (r_sr[4:0]   == TRL_PATTERN);

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            r_state  <= S_IDLE;
            r_sr     <= '0;
            r_bits   <= '0;
            r_word_a <= '0;
            r_word_b <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
            r_count  <= '0;
`ifdef ETHER_CMD_RX_TIMEOUT_EN
            r_to_cnt <= '0;
`endif
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_sample && !w_bit) begin
                        r_sr    <= {57'b0, w_bit};
                        r_bits  <= 6'd1;
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
`ifdef ETHER_CMD_RX_TIMEOUT_EN
                        r_to_cnt <= '0;
`endif
                    end
                end
                S_SHIFT: begin
                    if (w_sample) begin
                        r_sr   <= {r_sr[56:0], w_bit};
                        r_bits <= r_bits + 6'd1;
                        if (r_bits == 6'd57) begin
                            r_state <= S_CHECK;
                        end
`ifdef ETHER_CMD_RX_TIMEOUT_EN
                        r_to_cnt <= '0;
                    end else if (w_to_hit) begin
                        r_err    <= 1'b1;
                        r_busy   <= 1'b0;
                        r_sr     <= '0;
                        r_bits   <= '0;
                        r_to_cnt <= '0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_to_cnt <= w_to_next;
`endif
                    end
                end
                S_CHECK: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_bits  <= '0;
                    if (w_good) begin
                        r_word_a <= r_sr[38:23];
                        r_word_b <= r_sr[20:5];
                        r_count  <= r_count + 8'd1;
                        r_valid  <= 1'b1;
                    end else begin
                        r_err <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign word_a_out      = r_word_a;
    assign word_b_out      = r_word_b;
    assign frame_valid_out = r_valid;
    assign frame_err_out   = r_err;
    assign busy_out        = r_busy;
    assign frame_count_out = r_count;

endmodule

// File: tb/tb_ether_cmd_rx.sv
// Directed bench for ether_cmd_rx: frame table plus timing, reset,
// timeout and count sequences.
module tb_ether_cmd_rx;

    localparam int PH = 5;

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b0;
    logic        ser_clk_in = 1'b0;
    logic        ser_data_in = 1'b1;
    logic [15:0] word_a_out, word_b_out;
    logic        frame_valid_out, frame_err_out, busy_out;
    logic [7:0]  frame_count_out;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_err = 0;
    int n_both = 0;

    typedef struct {
        logic [57:0] frame;
        logic        good;
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  cnt;
    } vec_t;

    vec_t tbl[9];

    always #5 clk_in = ~clk_in;

`ifdef ETHER_CMD_RX_TIMEOUT_EN
    ether_cmd_rx #(.TIMEOUT_CYC(64)) dut (
`else
    ether_cmd_rx dut (
`endif
        .clk_in(clk_in),
        .reset_in(reset_in),
        .ser_clk_in(ser_clk_in),
        .ser_data_in(ser_data_in),
        .word_a_out(word_a_out),
        .word_b_out(word_b_out),
        .frame_valid_out(frame_valid_out),
        .frame_err_out(frame_err_out),
        .busy_out(busy_out),
        .frame_count_out(frame_count_out)
    );

    always @(negedge clk_in) begin
        if (frame_valid_out) n_valid = n_valid + 1;
        if (frame_err_out) n_err = n_err + 1;
        if (frame_valid_out && frame_err_out) n_both = n_both + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [57:0] mk(input logic [15:0] a,
                                       input logic [15:0] b);
        return {17'b00011000000000000, 2'b11, a, 2'b11, b, 5'b11000};
    endfunction

    // Called at a negedge; data changes with the falling serial clock.
    task automatic send_bit(input logic b);
        ser_data_in = b;
        repeat (PH) @(negedge clk_in);
        ser_clk_in = 1'b1;
        repeat (PH) @(negedge clk_in);
        ser_clk_in = 1'b0;
    endtask

    task automatic send_frame(input logic [57:0] f);
        for (int i = 57; i >= 0; i--) send_bit(f[i]);
    endtask

    task automatic settle();
        repeat (4) @(negedge clk_in);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic [15:0] a,
                           input logic [15:0] b, input logic [7:0] c);
        chk({nm, " word_a"}, word_a_out, a);
        chk({nm, " word_b"}, word_b_out, b);
        chk({nm, " count"}, frame_count_out, c);
        chk({nm, " busy"}, busy_out, 1'b0);
    endtask

    initial begin
        logic [57:0] f;
        int v0, e0;

        tbl[0] = '{mk(16'h000F, 16'h0000), 1'b1, 16'h000F, 16'h0000, 8'd1};
        tbl[1] = '{mk(16'h0003, 16'hFFFC), 1'b1, 16'h0003, 16'hFFFC, 8'd2};
        tbl[2] = '{mk(16'h0003, 16'hFFC3), 1'b1, 16'h0003, 16'hFFC3, 8'd3};
        f = mk(16'h000F, 16'h0000); f[40] = 1'b0;
        tbl[3] = '{f, 1'b0, 16'h0003, 16'hFFC3, 8'd3};
        f = mk(16'h000F, 16'h0000); f[39] = 1'b0;
        tbl[4] = '{f, 1'b0, 16'h0003, 16'hFFC3, 8'd3};
        f = mk(16'h000F, 16'h0000); f[22] = 1'b0;
        tbl[5] = '{f, 1'b0, 16'h0003, 16'hFFC3, 8'd3};
        f = mk(16'h000F, 16'h0000); f[50] = 1'b1;
        tbl[6] = '{f, 1'b0, 16'h0003, 16'hFFC3, 8'd3};
        f = mk(16'h000F, 16'h0000); f[0] = 1'b1;
        tbl[7] = '{f, 1'b0, 16'h0003, 16'hFFC3, 8'd3};
        tbl[8] = '{mk(16'hA5C3, 16'h5A3C), 1'b1, 16'hA5C3, 16'h5A3C, 8'd4};

        repeat (4) @(negedge clk_in);
        #1;
        chk("reset valid", frame_valid_out, 1'b0);
        chk("reset err", frame_err_out, 1'b0);
        chk_out("reset", 16'h0, 16'h0, 8'd0);
        @(negedge clk_in);
        reset_in = 1'b1;

        // Idle-high ones must not start a frame
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        settle();
        chk("idle busy", busy_out, 1'b0);
        chk("idle strobes", n_valid + n_err, 0);

        for (int i = 0; i < 9; i++) begin
            v0 = n_valid;
            e0 = n_err;
            send_frame(tbl[i].frame);
            settle();
            chk($sformatf("vec%0d valid", i), n_valid - v0, tbl[i].good);
            chk($sformatf("vec%0d err", i), n_err - e0, !tbl[i].good);
            chk_out($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cnt);
        end

        // Exact cycle timing of busy and the valid strobe
        f = mk(16'h1234, 16'hABCD);
        v0 = n_valid;
        @(negedge clk_in);
        ser_data_in = f[57];
        repeat (PH) @(negedge clk_in);
        ser_clk_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1 chk("t busy pre", busy_out, 1'b0);
        @(posedge clk_in);
        #1 chk("t busy rise", busy_out, 1'b1);
        repeat (PH - 2) @(negedge clk_in);
        ser_clk_in = 1'b0;
        for (int i = 56; i >= 1; i--) send_bit(f[i]);
        ser_data_in = f[0];
        repeat (PH) @(negedge clk_in);
        ser_clk_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1 chk("t check valid", frame_valid_out, 1'b0);
        chk("t check busy", busy_out, 1'b1);
        @(posedge clk_in);
        #1 chk("t valid", frame_valid_out, 1'b1);
        chk("t busy fall", busy_out, 1'b0);
        chk("t err", frame_err_out, 1'b0);
        @(posedge clk_in);
        #1 chk("t valid width", frame_valid_out, 1'b0);
        repeat (2) @(negedge clk_in);
        ser_clk_in = 1'b0;
        settle();
        chk("t valid count", n_valid - v0, 1);
        chk_out("t", 16'h1234, 16'hABCD, 8'd5);

`ifdef ETHER_CMD_RX_TIMEOUT_EN
        f = mk(16'h0F0F, 16'h3C3C);
        e0 = n_err;
        for (int i = 57; i >= 39; i--) send_bit(f[i]);
        ser_data_in = f[38];
        repeat (PH) @(negedge clk_in);
        ser_clk_in = 1'b1;
        repeat (5) @(posedge clk_in);
        @(negedge clk_in);
        ser_clk_in = 1'b0;
        repeat (60) @(posedge clk_in);
        #1 chk("to early", frame_err_out, 1'b0);
        chk("to busy hold", busy_out, 1'b1);
        @(posedge clk_in);
        #1 chk("to err", frame_err_out, 1'b1);
        chk("to busy", busy_out, 1'b0);
        settle();
        chk("to err count", n_err - e0, 1);
        v0 = n_valid;
        send_frame(f);
        settle();
        chk("to next valid", n_valid - v0, 1);
        chk_out("to next", 16'h0F0F, 16'h3C3C, 8'd6);
`endif

        // Reset after 30 bits; the tail starts a bad attempt at a 0 bit
        f = mk(16'h000F, 16'h0000);
        for (int i = 57; i >= 28; i--) send_bit(f[i]);
        reset_in = 1'b0;
        @(negedge clk_in);
        reset_in = 1'b1;
        #1;
        chk("mid rst valid", frame_valid_out, 1'b0);
        chk("mid rst err", frame_err_out, 1'b0);
        chk_out("mid rst", 16'h0, 16'h0, 8'd0);
        v0 = n_valid;
        e0 = n_err;
        for (int i = 27; i >= 0; i--) send_bit(f[i]);
        // 28 tail bits plus 30 idle ones fill out the stray attempt
        for (int i = 0; i < 30; i++) send_bit(1'b1);
        settle();
        chk("tail err", n_err - e0, 1);
        chk("tail valid", n_valid - v0, 0);
        send_frame(f);
        settle();
        chk("clean valid", n_valid - v0, 1);
        chk_out("clean", 16'h000F, 16'h0000, 8'd1);

        for (int i = 0; i < 16; i++) begin
            v0 = n_valid;
            send_frame(mk(16'(i * 16'h0101), 16'(~(i * 16'h0101))));
            settle();
            chk($sformatf("burst%0d valid", i), n_valid - v0, 1);
            chk($sformatf("burst%0d count", i), frame_count_out, 8'(i + 2));
        end
        chk("burst word_a", word_a_out, 16'h0F0F);
        chk("burst word_b", word_b_out, 16'hF0F0);

        chk("exclusive strobes", n_both, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
